warmup_key_driver: RTL and testbench
====================================

WARMUP_KEY_DRIVER -- requirements
Module: warmup_key_driver

Interface
REQ-001 Parameter KEY_LEN, default 4: number of warm-up key steps.
REQ-002 Parameter STEP_CYCLES, default 3: cycles each key step or request is held on the core inputs.
REQ-003 Parameter TIMEOUT, default 16: maximum cycles to wait for core_valid.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins the warm-up injection.
REQ-007 key_data  input  8*KEY_LEN  key step data; step 0 in the LSBs; sampled when start is accepted.
REQ-008 key_op  input  2*KEY_LEN  key step op; step 0 in the LSBs; sampled when start is accepted.
REQ-009 core_datain  output  8  drives the locked core's datain.
REQ-010 core_op  output  2  drives the locked core's op.
REQ-011 core_valid  input  1  valid from the locked core.
REQ-012 core_dataout  input  8  dataout from the locked core.
REQ-013 req_valid / req_ready  input / output  1 / 1  user request handshake.
REQ-014 req_data / req_op  input  8 / 2  user request payload.
REQ-015 rsp_valid / rsp_data  output  1 / 8  one-cycle response pulse and the captured core_dataout.
REQ-016 unlocked / unlock_fail  output  1 / 1  status flags; unlock_fail is sticky.
REQ-017 rsp_err  output  1  one-cycle pulse on request timeout.

Function
REQ-018 FSM states: IDLE, INJECT, WAIT_UNLOCK, READY, REQ_DRIVE, REQ_WAIT, FAIL.
REQ-019 IDLE: on start, latch the key, set step=0 and go to INJECT.
REQ-020 INJECT: drive key step `step` for exactly STEP_CYCLES cycles, then step+1; after step KEY_LEN-1 go to WAIT_UNLOCK.
REQ-021 WAIT_UNLOCK: drive 0/0 and count cycles; core_valid=1 goes to READY with unlocked=1; TIMEOUT cycles without it go to FAIL with unlock_fail=1.
REQ-022 If core_valid rises in the same cycle the timeout expires, valid wins.
REQ-023 READY: req_ready=1 combinationally, except in a cycle where start=1.
REQ-024 READY: a req_valid&&req_ready handshake latches req_data/req_op and goes to REQ_DRIVE.
REQ-025 REQ_DRIVE: drive the latched request for STEP_CYCLES cycles, then go to REQ_WAIT.
REQ-026 REQ_WAIT: the first core_valid captures core_dataout into rsp_data, pulses rsp_valid for 1 cycle and returns to READY.
REQ-027 REQ_WAIT: after TIMEOUT cycles, pulse rsp_err, clear unlocked and go to FAIL.
REQ-028 At most one request is outstanding; req_ready=0 in every state other than READY.
REQ-029 start in INJECT, WAIT_UNLOCK, REQ_DRIVE or REQ_WAIT is ignored.
REQ-030 start in READY or FAIL clears unlocked and unlock_fail and restarts from INJECT; it wins over a simultaneous req_valid.
REQ-031 core_valid is ignored in IDLE, INJECT, READY, REQ_DRIVE and FAIL.
REQ-032 Counters are sized $clog2(max(STEP_CYCLES,TIMEOUT,KEY_LEN))+1 and never wrap; they saturate at terminal count.
REQ-033 Core inputs are 0/0 in every state other than INJECT and REQ_DRIVE.

Reset
REQ-034 rst asynchronously forces IDLE, step=0, all counters=0 and all outputs 0, including rsp_data and both flags.
REQ-035 rst mid-injection or mid-request abandons the operation; no rsp_valid or rsp_err is issued afterwards.

Structure
REQ-036 A shared package warmup_pkg holds the state enum, the data width (8) and the op width (2).
REQ-037 One sub-module, warmup_hold_timer, is a loadable down-counter with a done flag; one instance each is used for step hold and for timeout.

Verification
REQ-038 Key {A5/1, 3C/2, FF/0, 00/3}, core model asserts valid 2 cycles after the last step -> 12 cycles of injection in order, then unlocked=1.
REQ-039 Core never asserts valid -> unlock_fail=1 exactly 16 cycles after the last step ends; req_ready stays 0.
REQ-040 Unlocked, request 0x42/op 1, core returns 0xBD -> a single rsp_valid with rsp_data=0xBD, and req_ready low until the response.
REQ-041 start and req_valid in the same READY cycle -> request not accepted, injection restarts, unlocked=0.
REQ-042 rst asserted during step 2 -> all outputs 0 immediately; a new start reinjects from step 0.
REQ-043 core_valid coincident with the timeout terminal cycle -> READY, unlock_fail stays 0.

Source files
------------

// File: rtl/warmup_pkg.sv
// Shared definitions for the warm-up key driver.
// Holds the controller state encoding, the core data/op widths and a small
// helper used to size the internal counters.
package warmup_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 2;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_INJECT      = 3'd1,
    ST_WAIT_UNLOCK = 3'd2,
    ST_READY       = 3'd3,
    ST_REQ_DRIVE   = 3'd4,
    ST_REQ_WAIT    = 3'd5,
    ST_FAIL        = 3'd6
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/warmup_hold_timer.sv
// Loadable saturating down-counter.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load     : load value into the counter this cycle
//   value    : load value; loading N gives N+1 cycles before done
//   done     : high while the count is zero
module warmup_hold_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] count;

  // Stops at zero instead of wrapping, so a timer left idle stays done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/warmup_key_driver.sv
// Warm-up key driver: injects a key sequence into a locked core, waits for
// the core to report unlock, then forwards single user requests to it.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start                    : pulse that (re)starts key injection
//   key_data / key_op        : key steps, step 0 in the LSBs, latched on start
//   core_datain / core_op    : drive the locked core (0/0 when not driving)
//   core_valid/core_dataout  : core response
//   req_valid/req_ready      : user request handshake
//   req_data / req_op        : user request payload
//   rsp_valid / rsp_data     : one-cycle response pulse and captured data
//   rsp_err                  : one-cycle pulse on request timeout
//   unlocked / unlock_fail   : status flags (unlock_fail is sticky)
//   dbg_state                : current controller state
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in READY and is pulled low
// in any cycle where start is high; it never depends on req_valid.
module warmup_key_driver
  import warmup_pkg::*;
#(
  parameter int KEY_LEN     = 4,
  parameter int STEP_CYCLES = 3,
  parameter int TIMEOUT     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATA_W*KEY_LEN-1:0] key_data,
  input  logic [OP_W*KEY_LEN-1:0]   key_op,
  output logic [DATA_W-1:0]      core_datain,
  output logic [OP_W-1:0]        core_op,
  input  logic                   core_valid,
  input  logic [DATA_W-1:0]      core_dataout,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [DATA_W-1:0]      req_data,
  input  logic [OP_W-1:0]        req_op,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   unlocked,
  output logic                   unlock_fail,
  output logic                   rsp_err,
  output logic [2:0]             dbg_state
);

  localparam int CW = $clog2(max3(STEP_CYCLES, TIMEOUT, KEY_LEN)) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(KEY_LEN - 1);
  localparam logic [CW-1:0] HOLD_VAL  = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] TMO_VAL   = CW'(TIMEOUT - 1);

  state_t state_q, state_d;
  logic [CW-1:0] step_q, step_d;
  logic [DATA_W*KEY_LEN-1:0] key_data_q, key_data_sel;
  logic [OP_W*KEY_LEN-1:0]   key_op_q, key_op_sel;
  logic [DATA_W-1:0] req_data_q;
  logic [OP_W-1:0]   req_op_q;

  logic hold_load, hold_done, tmo_load, tmo_done;
  logic do_restart, req_fire, unlock_ok, unlock_to, rsp_fire, err_fire;

  warmup_hold_timer #(.W(CW)) u_hold (
    .clk(clk), .rst(rst), .load(hold_load), .value(HOLD_VAL), .done(hold_done)
  );

  warmup_hold_timer #(.W(CW)) u_timeout (
    .clk(clk), .rst(rst), .load(tmo_load), .value(TMO_VAL), .done(tmo_done)
  );

  assign req_ready = (state_q == ST_READY) && !start;
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    hold_load  = 1'b0;
    tmo_load   = 1'b0;
    do_restart = 1'b0;
    req_fire   = 1'b0;
    unlock_ok  = 1'b0;
    unlock_to  = 1'b0;
    rsp_fire   = 1'b0;
    err_fire   = 1'b0;
    case (state_q)
      ST_IDLE, ST_READY, ST_FAIL: begin
        if (start) begin
          do_restart = 1'b1;
        end else if (state_q == ST_READY && req_valid) begin
          req_fire  = 1'b1;
          hold_load = 1'b1;
          state_d   = ST_REQ_DRIVE;
        end
      end
      ST_INJECT: begin
        if (hold_done) begin
          if (step_q == LAST_STEP) begin
            tmo_load = 1'b1;
            state_d  = ST_WAIT_UNLOCK;
          end else begin
            step_d    = step_q + CW'(1);
            hold_load = 1'b1;
          end
        end
      end
      // core_valid is checked before the timeout so a coincident valid wins.
      ST_WAIT_UNLOCK: begin
        if (core_valid) begin
          unlock_ok = 1'b1;
          state_d   = ST_READY;
        end else if (tmo_done) begin
          unlock_to = 1'b1;
          state_d   = ST_FAIL;
        end
      end
      ST_REQ_DRIVE: begin
        if (hold_done) begin
          tmo_load = 1'b1;
          state_d  = ST_REQ_WAIT;
        end
      end
      ST_REQ_WAIT: begin
        if (core_valid) begin
          rsp_fire = 1'b1;
          state_d  = ST_READY;
        end else if (tmo_done) begin
          err_fire = 1'b1;
          state_d  = ST_FAIL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (do_restart) begin
      state_d   = ST_INJECT;
      step_d    = '0;
      hold_load = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_data_q  <= '0;
      key_op_q    <= '0;
      req_data_q  <= '0;
      req_op_q    <= '0;
      unlocked    <= 1'b0;
      unlock_fail <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
    end else begin
      rsp_valid <= rsp_fire;
      rsp_err   <= err_fire;
      if (rsp_fire) rsp_data <= core_dataout;
      if (req_fire) begin
        req_data_q <= req_data;
        req_op_q   <= req_op;
      end
      if (do_restart) begin
        key_data_q  <= key_data;
        key_op_q    <= key_op;
        unlocked    <= 1'b0;
        unlock_fail <= 1'b0;
      end else begin
        if (unlock_ok) unlocked <= 1'b1;
        if (err_fire)  unlocked <= 1'b0;
        if (unlock_to) unlock_fail <= 1'b1;
      end
    end
  end

  // Current key step sits in the low bits after shifting by the step index.
  assign key_data_sel = key_data_q >> {step_q, 3'b000};
  assign key_op_sel   = key_op_q >> {step_q, 1'b0};

  always_comb begin
    core_datain = '0;
    core_op     = '0;
    if (state_q == ST_INJECT) begin
      core_datain = key_data_sel[DATA_W-1:0];
      core_op     = key_op_sel[OP_W-1:0];
    end else if (state_q == ST_REQ_DRIVE) begin
      core_datain = req_data_q;
      core_op     = req_op_q;
    end
  end

endmodule

// File: tb/tb_warmup_key_driver.sv
// Testbench for warmup_key_driver.
module tb_warmup_key_driver;

  localparam int KEY_LEN     = 4;
  localparam int STEP_CYCLES = 3;
  localparam int TIMEOUT     = 16;
  localparam int KW          = 8 * KEY_LEN;
  localparam int OW          = 2 * KEY_LEN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [KW-1:0] key_data = '0;
  logic [OW-1:0] key_op = '0;
  logic [7:0]    core_datain;
  logic [1:0]    core_op;
  logic          core_valid = 1'b0;
  logic [7:0]    core_dataout = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [7:0]    req_data = '0;
  logic [1:0]    req_op = '0;
  logic          rsp_valid;
  logic [7:0]    rsp_data;
  logic          unlocked;
  logic          unlock_fail;
  logic          rsp_err;
  logic [2:0]    dbg_state;

  warmup_key_driver #(
    .KEY_LEN(KEY_LEN), .STEP_CYCLES(STEP_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .key_data(key_data), .key_op(key_op),
    .core_datain(core_datain), .core_op(core_op), .core_valid(core_valid),
    .core_dataout(core_dataout), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .unlocked(unlocked), .unlock_fail(unlock_fail),
    .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];
  bit ready_m = 1'b0;   // model: controller is unlocked and idle in READY

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_datain"}, 32'(core_datain), 32'd0);
    check({tag, "_op"}, 32'(core_op), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    check({tag, "_unlocked"}, 32'(unlocked), 32'd0);
    check({tag, "_unlock_fail"}, 32'(unlock_fail), 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Start an injection of key kd/ko; the core answers d cycles into the wait
  // window (d >= TIMEOUT means it never answers).
  task automatic run_unlock(input logic [KW-1:0] kd, input logic [OW-1:0] ko,
                            input int d, input bit with_req);
    logic [9:0] exp;
    start = 1'b1; key_data = kd; key_op = ko; core_valid = 1'b0;
    req_valid = with_req; req_data = 8'($urandom); req_op = 2'($urandom);
    @(negedge clk);
    check("start_req_ready", 32'(req_ready), 32'd0);
    exp_q.delete();
    for (int s = 0; s < KEY_LEN; s++)
      for (int c = 0; c < STEP_CYCLES; c++)
        exp_q.push_back({ko[2*s +: 2], kd[8*s +: 8]});
    next_cycle();
    req_valid = 1'b0;
    for (int i = 0; i < KEY_LEN * STEP_CYCLES; i++) begin
      // Noise the core and key inputs; all of it must be ignored here.
      start = 1'($urandom_range(0, 3) == 0);
      key_data = KW'($urandom); key_op = OW'($urandom);
      core_valid = 1'($urandom_range(0, 1)); core_dataout = 8'($urandom);
      @(negedge clk);
      exp = exp_q.pop_front();
      check("inject_core", 32'({core_op, core_datain}), 32'(exp));
      check("inject_unlocked", 32'(unlocked), 32'd0);
      check("inject_unlock_fail", 32'(unlock_fail), 32'd0);
      check("inject_req_ready", 32'(req_ready), 32'd0);
      next_cycle();
    end
    for (int k = 0; k < TIMEOUT; k++) begin
      start = 1'b0;
      core_valid = 1'(k == d); core_dataout = 8'($urandom);
      @(negedge clk);
      check("wait_core", 32'({core_op, core_datain}), 32'd0);
      check("wait_unlocked", 32'(unlocked), 32'd0);
      check("wait_unlock_fail", 32'(unlock_fail), 32'd0);
      check("wait_req_ready", 32'(req_ready), 32'd0);
      next_cycle();
      if (k == d) break;
    end
    start = 1'b0; core_valid = 1'b0;
    @(negedge clk);
    if (d < TIMEOUT) begin
      check("unlock_unlocked", 32'(unlocked), 32'd1);
      check("unlock_fail_low", 32'(unlock_fail), 32'd0);
      check("unlock_req_ready", 32'(req_ready), 32'd1);
    end else begin
      check("timeout_unlocked", 32'(unlocked), 32'd0);
      check("timeout_unlock_fail", 32'(unlock_fail), 32'd1);
      check("timeout_req_ready", 32'(req_ready), 32'd0);
    end
    ready_m = (d < TIMEOUT);
    next_cycle();
  endtask

  // One request; the core answers r cycles into the wait window with rv.
  task automatic do_request(input logic [7:0] rd, input logic [1:0] ro,
                            input int r, input logic [7:0] rv);
    start = 1'b0; core_valid = 1'b0;
    req_valid = 1'b1; req_data = rd; req_op = ro;
    @(negedge clk);
    check("req_ready_accept", 32'(req_ready), 32'd1);
    next_cycle();
    for (int i = 0; i < STEP_CYCLES; i++) begin
      start = 1'($urandom_range(0, 3) == 0);
      req_valid = 1'($urandom_range(0, 1)); req_data = 8'($urandom);
      core_valid = 1'($urandom_range(0, 1)); core_dataout = 8'($urandom);
      @(negedge clk);
      check("drive_core", 32'({core_op, core_datain}), 32'({ro, rd}));
      check("drive_req_ready", 32'(req_ready), 32'd0);
      check("drive_rsp_valid", 32'(rsp_valid), 32'd0);
      next_cycle();
    end
    for (int k = 0; k < TIMEOUT; k++) begin
      start = 1'($urandom_range(0, 3) == 0);
      req_valid = 1'($urandom_range(0, 1));
      core_valid = 1'(k == r);
      core_dataout = (k == r) ? rv : 8'($urandom);
      @(negedge clk);
      check("rwait_core", 32'({core_op, core_datain}), 32'd0);
      check("rwait_req_ready", 32'(req_ready), 32'd0);
      check("rwait_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rwait_rsp_err", 32'(rsp_err), 32'd0);
      next_cycle();
      if (k == r) break;
    end
    start = 1'b0; core_valid = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    if (r < TIMEOUT) begin
      check("rsp_valid_pulse", 32'(rsp_valid), 32'd1);
      check("rsp_data", 32'(rsp_data), 32'(rv));
      check("rsp_err_low", 32'(rsp_err), 32'd0);
      check("rsp_req_ready", 32'(req_ready), 32'd1);
      check("rsp_unlocked", 32'(unlocked), 32'd1);
    end else begin
      check("rsp_err_pulse", 32'(rsp_err), 32'd1);
      check("rsp_err_valid_low", 32'(rsp_valid), 32'd0);
      check("rsp_err_unlocked", 32'(unlocked), 32'd0);
      check("rsp_err_req_ready", 32'(req_ready), 32'd0);
    end
    next_cycle();
    @(negedge clk);
    check("rsp_valid_single", 32'(rsp_valid), 32'd0);
    check("rsp_err_single", 32'(rsp_err), 32'd0);
    if (r < TIMEOUT) check("rsp_data_hold", 32'(rsp_data), 32'(rv));
    ready_m = (r < TIMEOUT);
    next_cycle();
  endtask

  // Assert reset between edges and check outputs clear immediately.
  task automatic mid_cycle_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_zero(tag);
    @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b0; req_valid = 1'b0; core_valid = 1'b0;
    @(negedge clk);
    check_zero({tag, "_held"});
    ready_m = 1'b0;
    next_cycle();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [KW-1:0] kd;
    logic [OW-1:0] ko;
    rst = 1'b1;
    #1 check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("after_reset");
    next_cycle();

    // Fixed key, core answers two cycles into the wait window.
    run_unlock({8'h00, 8'hFF, 8'h3C, 8'hA5}, {2'd3, 2'd0, 2'd2, 2'd1}, 2, 1'b0);
    do_request(8'h42, 2'd1, 3, 8'hBD);

    // Random mix of unlocks and requests, including timeouts.
    for (int n = 0; n < 14; n++) begin
      if (!ready_m) run_unlock(KW'($urandom), OW'($urandom), int'($urandom_range(0, 19)), 1'b0);
      else do_request(8'($urandom), 2'($urandom), int'($urandom_range(0, 19)), 8'($urandom));
    end

    // Core never answers, then restart from FAIL with valid on the terminal cycle.
    run_unlock(KW'($urandom), OW'($urandom), TIMEOUT + 5, 1'b0);
    run_unlock(KW'($urandom), OW'($urandom), TIMEOUT - 1, 1'b0);

    // start together with req_valid in READY restarts injection.
    run_unlock(KW'($urandom), OW'($urandom), 0, 1'b1);
    do_request(8'($urandom), 2'($urandom), 0, 8'($urandom));

    // Reset during key step 2.
    kd = KW'($urandom); ko = OW'($urandom);
    start = 1'b1; key_data = kd; key_op = ko;
    next_cycle();
    start = 1'b0;
    for (int i = 0; i < 2 * STEP_CYCLES + 1; i++) begin
      @(negedge clk);
      check("pre_reset_core", 32'({core_op, core_datain}),
            32'({ko[2*(i/STEP_CYCLES) +: 2], kd[8*(i/STEP_CYCLES) +: 8]}));
      next_cycle();
    end
    mid_cycle_reset("inject_reset");
    run_unlock(KW'($urandom), OW'($urandom), 5, 1'b0);

    // Reset while a request is waiting: no response may follow.
    req_valid = 1'b1; req_data = 8'($urandom); req_op = 2'($urandom);
    next_cycle();
    req_valid = 1'b0;
    repeat (STEP_CYCLES + 4) next_cycle();
    mid_cycle_reset("request_reset");
    for (int i = 0; i < 20; i++) begin
      core_valid = 1'($urandom_range(0, 1)); core_dataout = 8'($urandom);
      req_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("post_reset_rsp_err", 32'(rsp_err), 32'd0);
      check("post_reset_req_ready", 32'(req_ready), 32'd0);
      next_cycle();
    end
    core_valid = 1'b0; req_valid = 1'b0;
    run_unlock(KW'($urandom), OW'($urandom), 1, 1'b0);
    do_request(8'($urandom), 2'($urandom), 7, 8'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
